pci_slave: RTL and testbench

// - Simplified 32-bit PCI target: decodes address phase on shared AD bus, claims hits with DEVSEL#,

---
 rtl/pci_slave_pkg.sv | 24 ++
 rtl/pci_slave_if.sv | 27 ++
 rtl/pci_slave_mem.sv | 35 +++
 rtl/pci_slave.sv | 146 ++++++++++++++
 tb/tb_pci_slave.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/pci_slave_pkg.sv
// pci_slave_pkg: command codes, FSM states and command-class helpers for the PCI target.
package pci_slave_pkg;

  localparam logic [3:0] CMD_IO_RD  = 4'b0010;
  localparam logic [3:0] CMD_IO_WR  = 4'b0011;
  localparam logic [3:0] CMD_MEM_RD = 4'b0110;
  localparam logic [3:0] CMD_MEM_WR = 4'b0111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TURN  = 2'd1,
    RDATA = 2'd2,
    WDATA = 2'd3
  } state_t;

  function automatic logic is_read_cmd(input logic [3:0] cmd);
    return (cmd == CMD_IO_RD) || (cmd == CMD_MEM_RD);
  endfunction

  function automatic logic is_write_cmd(input logic [3:0] cmd);
    return (cmd == CMD_IO_WR) || (cmd == CMD_MEM_WR);
  endfunction

endpackage

// File: rtl/pci_slave_if.sv
// pci_slave_if: PCI bus signals between one initiator and the target.
// The shared AD bus is resolved here: the target drives it only while t_ad_oe
// is set, the initiator only while m_ad_oe is set, otherwise it floats.
interface pci_slave_if;
  logic [3:0]  cbe;
  logic        frame;
  logic        irdy;
  logic        trdy;
  logic        devsel;
  logic [31:0] t_ad;
  logic        t_ad_oe;
  logic [31:0] m_ad;
  logic        m_ad_oe;
  wire  [31:0] ad;

  assign ad = t_ad_oe ? t_ad : (m_ad_oe ? m_ad : {32{1'bz}});

  modport slave (
    input  ad, cbe, frame, irdy,
    output trdy, devsel, t_ad, t_ad_oe
  );

  modport master (
    input  ad, trdy, devsel, t_ad_oe,
    output cbe, frame, irdy, m_ad, m_ad_oe
  );
endinterface

// File: rtl/pci_slave_mem.sv
// pci_slave_mem: word-addressed register file, byte-enabled synchronous write,
// synchronous clear, combinational read.
module pci_slave_mem #(
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [3:0]           be,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [31:0]          wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [31:0]          rdata
);
  localparam int DEPTH = 1 << ADDR_BITS;

  logic [31:0] mem_r [DEPTH];

  // Clear all words on reset, otherwise merge enabled bytes into the addressed word.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'h0000_0000;
      end
    end else if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_r[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem_r[raddr];
endmodule

// File: rtl/pci_slave.sv
// pci_slave: simplified 32-bit PCI target. Claims I/O and memory reads/writes
// that fall in its window, with zero wait states on writes and one turnaround
// cycle before read data. Bursts wrap within the window.
module pci_slave
  import pci_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ADDR_BITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  pci_slave_if.slave bus
);
  localparam int                   HI      = ADDR_BITS + 2;
  localparam logic [ADDR_BITS-1:0] IDX_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  state_t               state_r, state_s;
  logic [ADDR_BITS-1:0] idx_r, idx_s;
  logic [31:0]          rd_r, rd_s;
  logic                 ignore_r, ignore_s;
  logic                 trdy_r, devsel_r, ad_oe_r;
  logic                 trdy_s, devsel_s, ad_oe_s;
  logic                 addr_ph_s, hit_s, xfer_s, mem_we_s;
  logic [ADDR_BITS-1:0] raddr_s;
  logic [31:0]          rdata_s;

  // ignore_r blocks data phases of an unclaimed transaction from being decoded as addresses
  assign addr_ph_s = (state_r == IDLE) && !bus.frame && !ignore_r;
  assign hit_s     = (bus.ad[31:HI] == BASE_ADDR[31:HI]);
  assign xfer_s    = !bus.irdy;
  assign mem_we_s  = (state_r == WDATA) && xfer_s;
  // In RDATA the next word is fetched ahead so it is ready after the transfer edge
  assign raddr_s   = (state_r == RDATA) ? (idx_r + IDX_ONE) : idx_r;

  pci_slave_mem #(.ADDR_BITS(ADDR_BITS)) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we_s),
    .be    (~bus.cbe),
    .waddr (idx_r),
    .wdata (bus.ad),
    .raddr (raddr_s),
    .rdata (rdata_s)
  );

  // State, index, read-data and registered bus outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      idx_r    <= {ADDR_BITS{1'b0}};
      rd_r     <= 32'h0000_0000;
      ignore_r <= 1'b0;
      trdy_r   <= 1'b1;
      devsel_r <= 1'b1;
      ad_oe_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      idx_r    <= idx_s;
      rd_r     <= rd_s;
      ignore_r <= ignore_s;
      trdy_r   <= trdy_s;
      devsel_r <= devsel_s;
      ad_oe_r  <= ad_oe_s;
    end
  end

  // Next state: address decode, burst index advance and read prefetch
  always_comb begin
    state_s  = state_r;
    idx_s    = idx_r;
    rd_s     = rd_r;
    ignore_s = ignore_r;
    case (state_r)
      IDLE: begin
        if (addr_ph_s) begin
          idx_s = bus.ad[HI-1:2];
          if (hit_s && is_read_cmd(bus.cbe)) begin
            state_s = TURN;
          end else if (hit_s && is_write_cmd(bus.cbe)) begin
            state_s = WDATA;
          end else begin
            ignore_s = 1'b1;
          end
        end else if (bus.frame) begin
          ignore_s = 1'b0;
        end else begin
          ignore_s = ignore_r;
        end
      end
      TURN: begin
        rd_s    = rdata_s;
        state_s = RDATA;
      end
      RDATA: begin
        if (xfer_s) begin
          idx_s   = idx_r + IDX_ONE;
          rd_s    = rdata_s;
          state_s = bus.frame ? IDLE : RDATA;
        end else begin
          state_s = RDATA;
        end
      end
      WDATA: begin
        if (xfer_s) begin
          idx_s   = idx_r + IDX_ONE;
          state_s = bus.frame ? IDLE : WDATA;
        end else begin
          state_s = WDATA;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Bus outputs for the upcoming state, registered alongside it
  always_comb begin
    trdy_s   = 1'b1;
    devsel_s = 1'b1;
    ad_oe_s  = 1'b0;
    case (state_s)
      IDLE: begin
        trdy_s   = 1'b1;
        devsel_s = 1'b1;
      end
      TURN: devsel_s = 1'b0;
      RDATA: begin
        devsel_s = 1'b0;
        trdy_s   = 1'b0;
        ad_oe_s  = 1'b1;
      end
      WDATA: begin
        devsel_s = 1'b0;
        trdy_s   = 1'b0;
      end
      default: begin
        trdy_s   = 1'b1;
        devsel_s = 1'b1;
      end
    endcase
  end

  assign bus.trdy    = trdy_r;
  assign bus.devsel  = devsel_r;
  assign bus.t_ad    = rd_r;
  assign bus.t_ad_oe = ad_oe_r;
endmodule

// File: tb/tb_pci_slave.sv
// tb_pci_slave: initiator-side bench for pci_slave with a read-data scoreboard.
module tb_pci_slave;
  import pci_slave_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pci_slave_if bus ();

  pci_slave #(.BASE_ADDR(32'h0000_0000), .ADDR_BITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] wbuf [8];
  logic        rd_active = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.frame   = 1'b1;
    bus.irdy    = 1'b1;
    bus.cbe     = 4'hF;
    bus.m_ad    = 32'h0000_0000;
    bus.m_ad_oe = 1'b0;
  endtask

  task automatic check_released(input string tag);
    check_val({tag, "_trdy"},   32'(bus.trdy),    32'd1);
    check_val({tag, "_devsel"}, 32'(bus.devsel),  32'd1);
    check_val({tag, "_oe"},     32'(bus.t_ad_oe), 32'd0);
  endtask

  // Scoreboard: every read data transfer pops the oldest expected word
  always @(negedge clk) begin
    if (rd_active && !bus.trdy && !bus.irdy) begin
      if (exp_q.size() == 0) begin
        check_val("sb_extra", 32'd0, 32'd1);
      end else begin
        check_val("rd_data", bus.ad, exp_q.pop_front());
        check_val("rd_oe", 32'(bus.t_ad_oe), 32'd1);
      end
    end
  end

  task automatic wr_burst(input logic [31:0] addr, input logic [3:0] cmd, input int n,
                          input logic [3:0] be);
    bus.frame = 1'b0; bus.irdy = 1'b1; bus.cbe = cmd; bus.m_ad = addr; bus.m_ad_oe = 1'b1;
    step();
    check_val("wr_devsel", 32'(bus.devsel), 32'd0);
    check_val("wr_trdy", 32'(bus.trdy), 32'd0);
    for (int i = 0; i < n; i++) begin
      bus.m_ad  = wbuf[i];
      bus.cbe   = be;
      bus.irdy  = 1'b0;
      bus.frame = (i == n - 1) ? 1'b1 : 1'b0;
      step();
    end
    check_released("wr_end");
    idle_bus();
    step();
  endtask

  task automatic rd_burst(input logic [31:0] addr, input logic [3:0] cmd, input int n,
                          input int wait_at);
    int   done   = 0;
    int   guard  = 0;
    logic xfer;
    logic waited = 1'b0;
    bus.frame = 1'b0; bus.irdy = 1'b1; bus.cbe = cmd; bus.m_ad = addr; bus.m_ad_oe = 1'b1;
    step();
    check_val("turn_devsel", 32'(bus.devsel), 32'd0);
    check_val("turn_trdy", 32'(bus.trdy), 32'd1);
    check_val("turn_oe", 32'(bus.t_ad_oe), 32'd0);
    bus.m_ad_oe = 1'b0; bus.cbe = 4'h0; bus.irdy = 1'b0;
    bus.frame   = (n == 1) ? 1'b1 : 1'b0;
    rd_active   = 1'b1;
    step();
    check_val("rd_lat_trdy", 32'(bus.trdy), 32'd0);
    check_val("rd_devsel", 32'(bus.devsel), 32'd0);
    while (done < n && guard < 32) begin
      guard++;
      if (done == wait_at && !waited) begin
        waited   = 1'b1;
        bus.irdy = 1'b1;
        for (int w = 0; w < 2; w++) begin
          step();
          check_val("wait_trdy", 32'(bus.trdy), 32'd0);
          if (exp_q.size() > 0) check_val("wait_ad", bus.ad, exp_q[0]);
          else check_val("wait_sb", 32'd0, 32'd1);
        end
        bus.irdy = 1'b0;
      end else begin
        bus.frame = (done == n - 1) ? 1'b1 : 1'b0;
        xfer      = !bus.trdy && !bus.irdy;
        step();
        if (xfer) done++;
      end
    end
    rd_active = 1'b0;
    check_val("rd_count", 32'(done), 32'(n));
    check_released("rd_end");
    check_val("sb_drain", 32'(exp_q.size()), 32'd0);
    idle_bus();
    step();
  endtask

  task automatic miss(input logic [31:0] addr, input logic [3:0] cmd);
    bus.frame = 1'b0; bus.irdy = 1'b1; bus.cbe = cmd; bus.m_ad = addr; bus.m_ad_oe = 1'b1;
    step();
    check_val("miss_a_devsel", 32'(bus.devsel), 32'd1);
    check_val("miss_a_trdy", 32'(bus.trdy), 32'd1);
    // data phase that looks like a claimable write address phase
    bus.irdy = 1'b0; bus.m_ad = 32'h0000_0008; bus.cbe = CMD_MEM_WR;
    step();
    check_val("miss_d_devsel", 32'(bus.devsel), 32'd1);
    check_val("miss_d_trdy", 32'(bus.trdy), 32'd1);
    bus.frame = 1'b1; bus.m_ad = 32'hDEAD_BEEF; bus.cbe = 4'h0;
    step();
    check_val("miss_l_devsel", 32'(bus.devsel), 32'd1);
    check_val("miss_l_trdy", 32'(bus.trdy), 32'd1);
    idle_bus();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_bus();
    rst = 1'b1;
    step();
    step();
    check_released("rst");
    rst = 1'b0;
    step();

    // Word 0 reads back 0 after reset
    exp_q.push_back(32'h0000_0000);
    rd_burst(32'h0000_0000, CMD_MEM_RD, 1, -1);

    // Single write then single I/O read
    wbuf[0] = 32'h0000_C9C5;
    wr_burst(32'h0000_0008, CMD_MEM_WR, 1, 4'b0000);
    exp_q.push_back(32'h0000_C9C5);
    rd_burst(32'h0000_0008, CMD_IO_RD, 1, -1);

    // Burst that wraps past the top word, read back with two wait states
    wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3; wbuf[3] = 32'd4;
    wr_burst(32'h0000_0038, CMD_IO_WR, 4, 4'b0000);
    exp_q.push_back(32'd1); exp_q.push_back(32'd2);
    exp_q.push_back(32'd3); exp_q.push_back(32'd4);
    rd_burst(32'h0000_0038, CMD_MEM_RD, 4, 2);
    exp_q.push_back(32'd3);
    rd_burst(32'h0000_0000, CMD_MEM_RD, 1, -1);
    exp_q.push_back(32'd2);
    rd_burst(32'h0000_003C, CMD_IO_RD, 1, -1);

    // Byte enables
    wbuf[0] = 32'hFFFF_FFFF;
    wr_burst(32'h0000_0010, CMD_MEM_WR, 1, 4'b0000);
    wbuf[0] = 32'h0000_0000;
    wr_burst(32'h0000_0010, CMD_MEM_WR, 1, 4'b1100);
    exp_q.push_back(32'hFFFF_0000);
    rd_burst(32'h0000_0010, CMD_MEM_RD, 1, -1);
    wbuf[0] = 32'h1234_5678;
    wr_burst(32'h0000_0010, CMD_IO_WR, 1, 4'b0101);
    exp_q.push_back(32'h12FF_5600);
    rd_burst(32'h0000_0010, CMD_MEM_RD, 1, -1);

    // Misses and unsupported commands leave memory untouched
    miss(32'h0000_1000, CMD_MEM_WR);
    exp_q.push_back(32'd3);
    rd_burst(32'h0000_0000, CMD_MEM_RD, 1, -1);
    miss(32'h0000_0008, 4'b0000);
    exp_q.push_back(32'h0000_C9C5);
    rd_burst(32'h0000_0008, CMD_MEM_RD, 1, -1);
    miss(32'h0000_1000, CMD_MEM_RD);

    // Reset in the middle of a read burst
    exp_q.push_back(32'd1);
    bus.frame = 1'b0; bus.irdy = 1'b1; bus.cbe = CMD_MEM_RD;
    bus.m_ad = 32'h0000_0038; bus.m_ad_oe = 1'b1;
    step();
    bus.m_ad_oe = 1'b0; bus.cbe = 4'h0; bus.irdy = 1'b0; rd_active = 1'b1;
    step();
    step();
    rd_active = 1'b0; bus.irdy = 1'b1; bus.frame = 1'b1; rst = 1'b1;
    step();
    check_released("midrst");
    check_val("midrst_sb", 32'(exp_q.size()), 32'd0);
    rst = 1'b0;
    idle_bus();
    step();
    exp_q.push_back(32'h0000_0000);
    rd_burst(32'h0000_0038, CMD_MEM_RD, 1, -1);
    exp_q.push_back(32'h0000_0000);
    rd_burst(32'h0000_0008, CMD_IO_RD, 1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
